// File: rtl/player_sequencer_if.sv
// Player-input and ship-control signal bundle for player_sequencer.
// master = the sequencer, slave = the environment (buttons, collision logic, ship).
interface player_sequencer_if;
    logic       btn_left_n;
    logic       btn_right_n;
    logic       btn_fire_n;
    logic       btn_start_n;
    logic       hit;
    logic       shot_done;
    logic       step_left;
    logic       step_right;
    logic       fire;
    logic       ship_rst;
    logic [1:0] lives;
    logic [2:0] state;
    logic       shot_busy;

    modport master (
        input  btn_left_n, btn_right_n, btn_fire_n, btn_start_n, hit, shot_done,
        output step_left, step_right, fire, ship_rst, lives, state, shot_busy
    );

    modport slave (
        output btn_left_n, btn_right_n, btn_fire_n, btn_start_n, hit, shot_done,
        input  step_left, step_right, fire, ship_rst, lives, state, shot_busy
    );
endinterface

// File: rtl/player_sequencer.sv
// Player game-flow sequencer: button sync, movement ticks, fire cooldown, lives and respawn.
// Optional PLAYER_PAUSE_EN adds a PAUSE state toggled by the start button during play.
module player_sequencer #(
    parameter int unsigned TICK_DIV      = 100000,
    parameter int unsigned FIRE_COOLDOWN = 40000000,
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned RESPAWN_TICKS = 50
) (
    input  logic               clk,
    input  logic               reset,
    player_sequencer_if.master bus
);
    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CoolW = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
    localparam int unsigned HitW  = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

`ifdef PLAYER_PAUSE_EN
    typedef enum logic [2:0] {
        StIdle = 3'd0, StPlay = 3'd1, StHit = 3'd2, StRespawn = 3'd3, StOver = 3'd4, StPause = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle = 3'd0, StPlay = 3'd1, StHit = 3'd2, StRespawn = 3'd3, StOver = 3'd4
    } state_e;
`endif

    state_e             state_q, state_d;
    // Button vectors: [0] left, [1] right, [2] fire, [3] start; all active-low.
    logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [CoolW-1:0]   cool_q, cool_d;
    logic [HitW-1:0]    hit_cnt_q, hit_cnt_d;
    logic [1:0]         lives_q, lives_d;
    logic               busy_q, busy_d;
    logic               step_left_q, step_left_d, step_right_q, step_right_d;
    logic               fire_q, fire_d, ship_rst_q, ship_rst_d;

    logic [3:0] falling;
    logic       tick, start_fall, fire_fall, left_held, right_held;

    assign falling    = prev_q & ~sync2_q;
    assign start_fall = falling[3];
    assign fire_fall  = falling[2];
    assign left_held  = ~sync2_q[0];
    assign right_held = ~sync2_q[1];
    assign tick       = (tick_q == TickW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start_fall) state_d = StPlay;
            StPlay: begin
                if (bus.hit) begin
                    state_d = (lives_q <= 2'd1) ? StOver : StHit;
                end
`ifdef PLAYER_PAUSE_EN
                else if (start_fall) begin
                    state_d = StPause;
                end
`endif
            end
            StHit:     if (tick && hit_cnt_q == HitW'(RESPAWN_TICKS - 1)) state_d = StRespawn;
            StRespawn: state_d = StPlay;
            StOver:    if (start_fall) state_d = StIdle;
`ifdef PLAYER_PAUSE_EN
            StPause:   if (start_fall) state_d = StPlay;
`endif
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        sync1_d      = {bus.btn_start_n, bus.btn_fire_n, bus.btn_right_n, bus.btn_left_n};
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        tick_d       = tick ? '0 : tick_q + 1'b1;
        cool_d       = (cool_q != '0) ? cool_q - 1'b1 : cool_q;
        hit_cnt_d    = hit_cnt_q;
        lives_d      = lives_q;
        busy_d       = busy_q;
        step_left_d  = 1'b0;
        step_right_d = 1'b0;
        fire_d       = 1'b0;
        ship_rst_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_fall) begin
                    lives_d    = 2'(LIVES_INIT);
                    ship_rst_d = 1'b1;
                    cool_d     = '0;
                end
            end
            StPlay: begin
                // A hit swallows any fire or step decided in the same cycle.
                if (bus.hit) begin
                    lives_d   = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    hit_cnt_d = '0;
                end else begin
                    fire_d       = fire_fall && !busy_q && (cool_q == '0);
                    step_left_d  = tick && left_held && !right_held;
                    step_right_d = tick && right_held && !left_held;
                end
            end
            StHit: begin
                if (tick) hit_cnt_d = hit_cnt_q + 1'b1;
                // Pulse lines up with the single RESPAWN cycle.
                ship_rst_d = (state_d == StRespawn);
            end
`ifdef PLAYER_PAUSE_EN
            StPause:   cool_d = cool_q;
`endif
            default: ;
        endcase
        if (fire_d) cool_d = CoolW'(FIRE_COOLDOWN - 1);
        if ((state_q == StIdle && start_fall) || state_q == StRespawn) begin
            busy_d = 1'b0;
        end else if (fire_d) begin
            busy_d = 1'b1;
        end else if (bus.shot_done) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            prev_q       <= '1;
            tick_q       <= '0;
            cool_q       <= '0;
            hit_cnt_q    <= '0;
            lives_q      <= 2'd0;
            busy_q       <= 1'b0;
            step_left_q  <= 1'b0;
            step_right_q <= 1'b0;
            fire_q       <= 1'b0;
            ship_rst_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            tick_q       <= tick_d;
            cool_q       <= cool_d;
            hit_cnt_q    <= hit_cnt_d;
            lives_q      <= lives_d;
            busy_q       <= busy_d;
            step_left_q  <= step_left_d;
            step_right_q <= step_right_d;
            fire_q       <= fire_d;
            ship_rst_q   <= ship_rst_d;
        end
    end

    assign bus.step_left  = step_left_q;
    assign bus.step_right = step_right_q;
    assign bus.fire       = fire_q;
    assign bus.ship_rst   = ship_rst_q;
    assign bus.lives      = lives_q;
    assign bus.state      = state_q;
    assign bus.shot_busy  = busy_q;
endmodule
